// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared constants for the video RAM path. The VBS generator uses the same
// address and data widths. Also holds the arbiter state encoding and a helper
// that sizes the write-FIFO occupancy counter.
// ---------------------------------------------------------------------------
package video_pkg;

  localparam int VRAM_ADDR_WIDTH = 11;
  localparam int VRAM_DATA_WIDTH = 8;

  // IDLE: free to sample a CPU request.
  // READ_PEND: a CPU read was accepted while video held the RAM and is
  // waiting for a free cycle.
  typedef enum logic {
    IDLE      = 1'b0,
    READ_PEND = 1'b1
  } arb_state_t;

  // The occupancy counter must represent 0..depth inclusive.
  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vram_write_fifo.sv
// ---------------------------------------------------------------------------
// vram_write_fifo
// Small synchronous FIFO that holds posted CPU writes ({addr, data}) until
// the arbiter finds a RAM cycle that video does not need.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset (clears pointers and count)
//   push       write push_data at the tail
//   push_data  entry to enqueue
//   pop        drop the head entry
//   head       current head entry (combinational from storage)
//   full       DEPTH entries held
//   empty      no entries held
//
// A push while full is taken only when a pop happens in the same cycle, so
// the count stays at DEPTH. DEPTH must be a power of two; the pointers wrap
// by natural overflow.
// ---------------------------------------------------------------------------
module vram_write_fifo
  import video_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = fifo_count_width(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = store[rd_ptr_reg];

  // Storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/video_ram_arbiter.sv
// ---------------------------------------------------------------------------
// video_ram_arbiter
// Single-port video RAM shared by the scan-out fetcher and the Z8 CPU.
// Video fetches always win and return data one cycle later. CPU reads use
// idle cycles. CPU writes are posted through vram_write_fifo and drain on
// any cycle with neither a video fetch nor a CPU read issue.
//
// Ports:
//   clk         system clock (pixel clock)
//   reset       synchronous active-high reset
//   vid_req     video fetch this cycle
//   vid_addr    video fetch address
//   vid_data    fetched byte, valid the cycle after vid_req, held otherwise
//   cpu_req     CPU request, held until cpu_ack
//   cpu_we      1 = write, 0 = read
//   cpu_addr    CPU address
//   cpu_wdata   CPU write data
//   cpu_ack     one-cycle accept (write) / completion (read) pulse
//   cpu_rdata   read data, valid while cpu_ack is high after a read
//   fifo_empty  no posted writes outstanding
// ---------------------------------------------------------------------------
module video_ram_arbiter
  import video_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = VRAM_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_data,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  fifo_empty
);

  localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int RAM_WORDS   = 2 ** ADDR_WIDTH;

  // RAM and its single registered read port
  logic [DATA_WIDTH-1:0] mem [RAM_WORDS];
  logic [DATA_WIDTH-1:0] ram_q_reg;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_re;
  logic                  ram_we;

  // Arbiter state
  arb_state_t            state_reg;
  arb_state_t            state_next;
  logic [ADDR_WIDTH-1:0] pend_addr_reg;
  logic                  cpu_ack_reg;

  // Which master the RAM output belongs to in the current cycle
  logic                  vid_sel_reg;
  logic                  rd_sel_reg;
  logic [DATA_WIDTH-1:0] vid_hold_reg;
  logic [DATA_WIDTH-1:0] rdata_hold_reg;

  // Per-cycle decisions
  logic                  sample;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  read_issue;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic [ENTRY_WIDTH-1:0] fifo_head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign head_addr = fifo_head[ENTRY_WIDTH-1:DATA_WIDTH];
  assign head_data = fifo_head[DATA_WIDTH-1:0];

  vram_write_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_accept),
    .push_data ({cpu_addr, cpu_wdata}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state and per-cycle arbitration. The evaluation order matters:
  // the read issue decides whether the FIFO may pop, and the pop decides
  // whether a write to a full FIFO can be accepted in the same cycle.
  always_comb begin
    state_next = state_reg;
    read_issue = 1'b0;
    read_addr  = cpu_addr;

    // Not sampling while the ack is high avoids taking the same request twice.
    sample    = cpu_req && !cpu_ack_reg && (state_reg == IDLE);
    // Reads wait for the FIFO to drain so they never see stale data.
    rd_accept = sample && !cpu_we && fifo_empty;

    case (state_reg)
      IDLE: begin
        if (rd_accept) begin
          if (vid_req) begin
            state_next = READ_PEND;
          end else begin
            read_issue = 1'b1;
          end
        end
      end
      READ_PEND: begin
        read_addr = pend_addr_reg;
        if (!vid_req) begin
          read_issue = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    fifo_pop  = !fifo_empty && !vid_req && !read_issue;
    wr_accept = sample && cpu_we && (!fifo_full || fifo_pop);

    ram_re = vid_req || read_issue;
    ram_we = fifo_pop;
    if (vid_req) begin
      ram_addr = vid_addr;
    end else if (read_issue) begin
      ram_addr = read_addr;
    end else begin
      ram_addr = head_addr;
    end
  end

  // Single-port synchronous RAM. A drain write coinciding with reset is
  // suppressed so a reset really discards every queued write.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      mem[ram_addr] <= head_data;
    end
    if (ram_re) begin
      ram_q_reg <= mem[ram_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pend_addr_reg  <= '0;
      cpu_ack_reg    <= 1'b0;
      vid_sel_reg    <= 1'b0;
      rd_sel_reg     <= 1'b0;
      vid_hold_reg   <= '0;
      rdata_hold_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cpu_ack_reg <= wr_accept || read_issue;
      vid_sel_reg <= vid_req;
      rd_sel_reg  <= read_issue;
      if (rd_accept) begin
        pend_addr_reg <= cpu_addr;
      end
      // Capture the RAM output when it belonged to a master, so each output
      // keeps its last value while the shared read register moves on.
      if (vid_sel_reg) begin
        vid_hold_reg <= ram_q_reg;
      end
      if (rd_sel_reg) begin
        rdata_hold_reg <= ram_q_reg;
      end
    end
  end

  assign vid_data  = vid_sel_reg ? ram_q_reg : vid_hold_reg;
  assign cpu_rdata = rd_sel_reg  ? ram_q_reg : rdata_hold_reg;
  assign cpu_ack   = cpu_ack_reg;

endmodule
